// File: rtl/seq_trigger.sv
// seq_trigger: multi-stage masked pattern sequencer that pulses MISO after the final stage matches
module seq_trigger #(
    parameter int W       = 32,
    parameter int DEPTH   = 4,
    parameter int OFFSET  = 1,
    parameter int RESTART = 1
) (
    input  logic                     SCLK,
    input  logic                     RST,
    input  logic [W-1:0]             MOSI,
    input  logic                     start,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [W-1:0]             cfg_mask,
    input  logic [W-1:0]             cfg_pattern,
    input  logic                     cfg_clear,
    output logic                     MISO,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] stage,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);
    localparam int SW = $clog2(DEPTH);
    localparam int CW = SW + 1;
    typedef enum logic [1:0] {IDLE, DELAY, MATCH, DONE} state_t;
    state_t        r_state, w_state;
    logic [SW-1:0] r_stage, w_stage;
    logic [CW-1:0] r_count;
    logic [15:0]   r_dly, w_dly;
    logic          r_miso, w_miso, r_ovf;
    logic [W-1:0]  r_mask [DEPTH];
    logic [W-1:0]  r_pat  [DEPTH];
    logic          w_idle, w_full, w_wr, w_hit, w_last;
    assign w_idle    = r_state == IDLE;
    assign w_full    = r_count == CW'(DEPTH);
    assign cfg_ready = w_idle && !w_full && !RST;
    assign w_wr      = cfg_valid && cfg_ready && !cfg_clear;
    assign w_hit     = ((MOSI ^ r_pat[r_stage]) & r_mask[r_stage]) == '0;
    assign w_last    = CW'(r_stage) + CW'(1) == r_count;
    assign MISO      = r_miso;
    assign busy      = !w_idle;
    assign stage     = r_stage;
    assign count     = r_count;
    assign ovf       = r_ovf;
    always_comb begin
        w_state = r_state;
        w_stage = r_stage;
        w_dly   = r_dly;
        w_miso  = 1'b0;
        case (r_state)
            IDLE: if (start && r_count != '0) begin
                w_stage = '0;
                w_dly   = 16'(OFFSET);
                w_state = (OFFSET > 0) ? DELAY : MATCH;
            end
            DELAY: if (!start) begin
                w_state = IDLE;
                w_stage = '0;
                w_dly   = '0;
            end else begin
                w_dly   = r_dly - 16'd1;
                w_state = (r_dly == 16'd1) ? MATCH : DELAY;
            end
            MATCH: if (!start) begin
                w_state = IDLE;
                w_stage = '0;
            end else if (w_hit && w_last) begin
                w_miso  = 1'b1;
                w_state = DONE;
            end else if (w_hit) begin
                w_stage = r_stage + SW'(1);
            end else begin
                w_stage = (RESTART != 0) ? '0 : r_stage;
            end
            DONE: w_state = start ? DONE : IDLE;
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge SCLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_stage <= '0;
            r_dly   <= '0;
            r_miso  <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_stage <= w_stage;
            r_dly   <= w_dly;
            r_miso  <= w_miso;
            if (w_idle && cfg_clear) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (w_wr) begin
                r_count <= r_count + CW'(1);
            end else if (w_idle && cfg_valid && w_full) begin
                r_ovf   <= 1'b1;
            end
        end
    end
    always_ff @(posedge SCLK) begin
        if (w_wr) begin
            r_mask[r_count[SW-1:0]] <= cfg_mask;
            r_pat[r_count[SW-1:0]]  <= cfg_pattern;
        end
    end
endmodule

// File: doc/seq_trigger.md
SEQ_TRIGGER -- requirements
Module: seq_trigger

Interface
REQ-001 SHALL have parameter W, default 32: width of sampled data, mask and pattern.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries in the stage table; power of two, 2..16.
REQ-003 SHALL have parameter OFFSET, default 1: number of cycles to skip between arming and the first compare, 0..65535.
REQ-004 SHALL have parameter RESTART, default 1: on a mismatch, 1 = return to stage 0; 0 = hold the current stage.
REQ-005 SCLK  in  1  sole clock; all logic on rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 MOSI  in  W  sampled data word, one per cycle.
REQ-008 start  in  1  arm level; high = run, low = abort/idle.
REQ-009 cfg_valid  in  1  stage-entry write request.
REQ-010 cfg_ready  out  1  write accept; = (state==IDLE) && !full.
REQ-011 cfg_mask  in  W  entry mask; bit 1 = compare that bit.
REQ-012 cfg_pattern  in  W  entry pattern.
REQ-013 cfg_clear  in  1  empty the stage table.
REQ-014 MISO  out  1  trigger pulse, registered.
REQ-015 busy  out  1  high in DELAY, MATCH or DONE.
REQ-016 stage  out  clog2(DEPTH)  index of the entry currently compared.
REQ-017 count  out  clog2(DEPTH)+1  number of valid entries.
REQ-018 ovf  out  1  sticky flag: write attempted while full; cleared by RST or cfg_clear.

Function
REQ-019 Entry write occurs on an edge with cfg_valid && cfg_ready: entry[count] <= {mask, pattern}; count += 1.
REQ-020 Entries SHALL persist across trigger runs; only RST or cfg_clear empties the table.
REQ-021 cfg_clear in IDLE SHALL set count=0 and ovf=0; if asserted with cfg_valid on the same edge, clear wins and no write occurs; cfg_clear outside IDLE SHALL be ignored.
REQ-022 cfg_valid while full in IDLE SHALL leave the table unchanged and set ovf.
REQ-023 cfg_valid outside IDLE SHALL be ignored without setting ovf.
REQ-024 Match condition for entry i: ((MOSI ^ pattern_i) & mask_i) == 0; an all-zero mask always matches.
REQ-025 FSM states: IDLE, DELAY, MATCH, DONE.
REQ-026 IDLE transitions on start=1 && count>0:
- to DELAY with down-counter=OFFSET when OFFSET>0;
- else to MATCH;
- stage=0 in both cases.
REQ-027 start=1 with count=0 SHALL keep the block in IDLE.
REQ-028 DELAY SHALL decrement the counter each edge and enter MATCH on the edge where the counter is 1.
REQ-029 First compare timing: with arming edge E0, the first compare uses MOSI sampled at edge E0+OFFSET+1.
REQ-030 MATCH, each edge: on a match with stage<count-1, stage += 1.
REQ-031 MATCH, each edge: on a match with stage==count-1, MISO<=1 for exactly one cycle and state goes to DONE.
REQ-032 MATCH, each edge: on a mismatch, stage<=0 if RESTART=1, else stage unchanged.
REQ-033 With RESTART=1, a mismatch at stage>0 SHALL NOT re-evaluate entry 0 on the same sample.
REQ-034 Trigger latency: MISO high during the cycle following the sampling edge of the final match.
REQ-035 DONE SHALL hold MISO=0 until start=0, then go to IDLE; re-arming requires a fresh start.
REQ-036 start=0 in DELAY or MATCH SHALL abort to IDLE, with stage=0 and MISO=0, on that edge.
REQ-037 A single-entry table SHALL trigger on the first matching sample.
REQ-038 Arithmetic: the delay counter is 16-bit; stage and count are unsigned with no wrap, since count saturates at DEPTH and stage stays below count.

Reset
REQ-039 RST sampled high SHALL, on that edge, force IDLE with stage=0, count=0, ovf=0, MISO=0, busy=0 and delay counter=0.
REQ-040 RST mid-run SHALL suppress any MISO pulse pending on that edge.
REQ-041 Table contents need not be cleared by RST; entries at index >= count are never compared.
REQ-042 cfg_ready SHALL be 0 during RST and 1 in the cycle after RST deasserts.

Verification
REQ-043 Scenario, basic: W=32, OFFSET=1; write entry {mask=FFFFFFFF, pattern=000000A5}; start=1; MOSI=A5 from the edge after arming -> MISO is one 1-cycle pulse, then DONE.
REQ-044 Scenario, 3-stage sequence {0x01, 0x02, 0x03} with full masks: MOSI 01,02,03 -> pulse after 03; MOSI 01,05,02,03 with RESTART=1 -> no pulse; same MOSI with RESTART=0 -> pulse.
REQ-045 Scenario, masking: mask=0000000F, pattern=00000003; MOSI=ABCD1233 -> match; MOSI=ABCD1234 -> no match.
REQ-046 Scenario, full table: write 5 entries with DEPTH=4 -> count=4, ovf=1; cfg_clear -> count=0, ovf=0; start=1 with count=0 -> busy stays 0.
REQ-047 Scenario, abort and offset: OFFSET=3; start dropped in DELAY -> IDLE, no pulse; re-arm -> first compare at E0+4.
REQ-048 Scenario, reset mid-run: RST asserted on the edge of the final match -> MISO stays 0; block is in IDLE with count=0.
